// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: op codes, FSM states,
// data-memory address width and op decode helpers.
package load_store_unit_pkg;

  localparam int DMEM_AW = 8;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LW   = 4'd1,
    OP_LH   = 4'd2,
    OP_LHU  = 4'd3,
    OP_LB   = 4'd4,
    OP_LBU  = 4'd5,
    OP_SW   = 4'd6,
    OP_SH   = 4'd7,
    OP_SB   = 4'd8
  } lsu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RMW  = 1'b1
  } lsu_state_e;

  function automatic lsu_op_e op_decode(logic [3:0] raw);
    return (raw > 4'd8) ? OP_NONE : lsu_op_e'(raw);
  endfunction

  // Offset bits that must be zero for the access size.
  function automatic logic [1:0] op_mask(lsu_op_e op);
    case (op)
      OP_LW, OP_SW:         return 2'b11;
      OP_LH, OP_LHU, OP_SH: return 2'b01;
      default:              return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-stage request channel into the load/store unit
// (valid/ready handshake plus request payload).
interface load_store_unit_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_op;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;

  modport master (
    output ex_valid, ex_op, ex_addr,
    output ex_wdata, ex_rd,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_op, ex_addr,
    input  ex_wdata, ex_rd,
    output ex_ready
  );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Byte/halfword lane logic: load extract with sign/zero
// extension, and sub-word store merge into a memory word.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  lsu_op_e     op,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [15:0] data,
  output logic [31:0] load_data,
  output logic [31:0] merge_word
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    load_data  = word;
    merge_word = word;
    unique case (1'b1)
      (op == OP_LH):  load_data = {{16{h[15]}}, h};
      (op == OP_LHU): load_data = {16'h0000, h};
      (op == OP_LB):  load_data = {{24{b[7]}}, b};
      (op == OP_LBU): load_data = {24'h000000, b};
      (op == OP_SH):
        merge_word[{off[1], 4'b0000} +: 16] = data;
      (op == OP_SB):
        merge_word[{off, 3'b000} +: 8] = data[7:0];
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: 1-cycle loads, single-cycle SW, 2-cycle SH/SB RMW.
// Misaligned accesses trap when LSU_MISALIGN_TRAP_EN is defined.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  load_store_unit_if.slave   ex,
  output logic               wb_valid,
  output logic [4:0]         wb_rd,
  output logic [31:0]        wb_data,
  output logic               misalign_err,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  output logic               dmem_wen,
  input  logic [31:0]        dmem_rdata
);

  lsu_state_e         state_q, state_d;
  lsu_op_e            op;
  logic [1:0]         off;
  logic               mis, rdy, acc;
  logic               is_load, is_sub;
  logic [DMEM_AW-1:0] addr_q;
  logic [31:0]        merged_q;
  logic [31:0]        load_data, merge_word;
  logic               unused_hi;

  assign unused_hi = ^ex.ex_addr[31:DMEM_AW];

  assign op  = op_decode(ex.ex_op);
  assign off = ex.ex_addr[1:0] & ~op_mask(op);

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = |(ex.ex_addr[1:0] & op_mask(op));
`else
  assign mis = 1'b0;
`endif

  assign rdy         = resetn && (state_q == S_IDLE);
  assign ex.ex_ready = rdy;
  assign acc         = ex.ex_valid && rdy;

  assign is_load = (op == OP_LW)  || (op == OP_LH) ||
                   (op == OP_LHU) || (op == OP_LB) ||
                   (op == OP_LBU);
  assign is_sub  = (op == OP_SH) || (op == OP_SB);

  lsu_lane_align u_align (
    .op         (op),
    .off        (off),
    .word       (dmem_rdata),
    .data       (ex.ex_wdata[15:0]),
    .load_data  (load_data),
    .merge_word (merge_word)
  );

  always_comb begin
    state_d    = state_q;
    dmem_wen   = 1'b0;
    dmem_addr  = {ex.ex_addr[DMEM_AW-1:2], 2'b00};
    dmem_wdata = ex.ex_wdata;
    unique case (state_q)
      S_IDLE: begin
        if (acc && !mis) begin
          if (op == OP_SW) dmem_wen = 1'b1;
          if (is_sub)      state_d  = S_RMW;
        end
      end
      S_RMW: begin
        dmem_addr  = addr_q;
        dmem_wdata = merged_q;
        // A reset landing here drops the pending write.
        dmem_wen   = resetn;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      merged_q <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      state_q  <= state_d;
      wb_valid <= acc && is_load && !mis;
      if (acc && is_load && !mis) begin
        wb_rd   <= ex.ex_rd;
        wb_data <= load_data;
      end
      if (acc && is_sub && !mis) begin
        addr_q   <= {ex.ex_addr[DMEM_AW-1:2], 2'b00};
        merged_q <= merge_word;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (!resetn) misalign_err <= 1'b0;
    else         misalign_err <= acc && mis;
  end
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus
// randomized traffic checked against a transaction-level model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if exi();

  logic        wb_valid, misalign_err, dmem_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_addr;

  load_store_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .ex           (exi),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .misalign_err (misalign_err),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_wen     (dmem_wen),
    .dmem_rdata   (dmem_rdata)
  );

  // Memory attached to the DUT
  logic [31:0] dut_mem [64];
  logic        mem_clr = 1'b0;
  logic        bd_en = 1'b0;
  logic [5:0]  bd_idx = '0;
  logic [31:0] bd_val = '0;

  assign dmem_rdata = dut_mem[dmem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) dut_mem[i] <= '0;
    end else if (dmem_wen) begin
      dut_mem[dmem_addr[7:2]] <= dmem_wdata;
    end else if (bd_en) begin
      dut_mem[bd_idx] <= bd_val;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  function automatic int op_bytes(int op);
    if (op == OP_LW || op == OP_SW) return 4;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] model_load(int op,
      logic [31:0] word, int off);
    longint v, span;
    int n;
    n = op_bytes(op);
    span = 64'd1 << (8 * n);
    v = {32'b0, word} >> (8 * off);
    v = v % span;
    if ((op == OP_LH || op == OP_LB) && v >= span / 2)
      v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_merge(int op,
      logic [31:0] word, logic [31:0] data, int off);
    longint span, mask, r;
    span = 64'd1 << (8 * op_bytes(op));
    mask = (span - 1) << (8 * off);
    r = ({32'b0, word} & ~mask) |
        (({32'b0, data} << (8 * off)) & mask);
    return r[31:0];
  endfunction

  // Reference model state
  logic [31:0] ref_mem [64];
  logic        pend = 1'b0;
  int          pend_idx = 0;
  logic [31:0] pend_word = '0;
  logic        exp_wbv = 1'b0, exp_mis = 1'b0, exp_zero = 1'b0;
  logic [4:0]  exp_rd = '0;
  logic [31:0] exp_data = '0;
  logic        armed = 1'b0;
  logic        acc_now = 1'b0;

  int          m_op, m_a, m_n, m_off, m_idx;
  logic        m_mis, m_rdy, m_wen;
  logic [7:0]  m_adr;
  logic [31:0] m_wd;

  always @(negedge clk) begin
    m_op = int'(exi.ex_op);
    m_a  = int'(exi.ex_addr[7:0]);
    m_n  = op_bytes(m_op);
`ifdef LSU_MISALIGN_TRAP_EN
    m_mis = (m_n > 0) && ((m_a % m_n) != 0);
`else
    m_mis = 1'b0;
`endif
    m_off = (m_n > 0) ? (m_a % 4) - (m_a % m_n) : 0;
    m_idx = m_a / 4;
    m_rdy = resetn && !pend;
    acc_now = m_rdy && exi.ex_valid;
    m_wen = 1'b0;
    m_adr = 8'(m_idx * 4);
    m_wd  = exi.ex_wdata;
    if (pend) begin
      m_adr = 8'(pend_idx * 4);
      m_wd  = pend_word;
      m_wen = resetn;
    end else if (acc_now && m_op == OP_SW && !m_mis) begin
      m_wen = 1'b1;
    end

    if (armed) begin
      chk("ex_ready", 32'(exi.ex_ready), 32'(m_rdy));
      chk("dmem_wen", 32'(dmem_wen), 32'(m_wen));
      if (m_wen || m_rdy) chk("dmem_addr", 32'(dmem_addr), 32'(m_adr));
      if (m_wen) chk("dmem_wdata", dmem_wdata, m_wd);
      chk("wb_valid", 32'(wb_valid), 32'(exp_wbv));
      chk("misalign_err", 32'(misalign_err), 32'(exp_mis));
      if (exp_wbv || exp_zero) begin
        chk("wb_rd", 32'(wb_rd), 32'(exp_rd));
        chk("wb_data", wb_data, exp_data);
      end
    end

    exp_wbv = 1'b0;
    exp_mis = 1'b0;
    exp_zero = 1'b0;
    if (!resetn) begin
      pend = 1'b0;
      exp_zero = 1'b1;
      exp_rd = '0;
      exp_data = '0;
      armed = 1'b1;
    end else if (pend) begin
      ref_mem[pend_idx] = pend_word;
      pend = 1'b0;
    end else if (acc_now) begin
      if (m_mis) begin
        exp_mis = 1'b1;
      end else if (m_op >= OP_LW && m_op <= OP_LBU) begin
        exp_wbv  = 1'b1;
        exp_rd   = exi.ex_rd;
        exp_data = model_load(m_op, ref_mem[m_idx], m_off);
      end else if (m_op == OP_SW) begin
        ref_mem[m_idx] = exi.ex_wdata;
      end else if (m_op == OP_SH || m_op == OP_SB) begin
        pend = 1'b1;
        pend_idx = m_idx;
        pend_word = model_merge(m_op, ref_mem[m_idx],
                                exi.ex_wdata, m_off);
      end
    end
    if (bd_en && !m_wen) ref_mem[bd_idx] = bd_val;
    if (mem_clr) for (int i = 0; i < 64; i++) ref_mem[i] = '0;
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic backdoor(int idx, logic [31:0] val);
    bd_en = 1'b1;
    bd_idx = 6'(idx);
    bd_val = val;
    idle(1);
    bd_en = 1'b0;
  endtask

  task automatic req(lsu_op_e op, logic [31:0] addr,
                     logic [31:0] data, logic [4:0] rd);
    bit ok;
    ok = 1'b0;
    exi.ex_valid = 1'b1;
    exi.ex_op = op;
    exi.ex_addr = addr;
    exi.ex_wdata = data;
    exi.ex_rd = rd;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(posedge clk);
      ok = acc_now;
    end
    #1;
    exi.ex_valid = 1'b0;
    if (!ok) chk("req_timeout", 32'(ok), 32'd1);
  endtask

  logic [31:0] r;

  initial begin
    exi.ex_valid = 1'b0;
    exi.ex_op = '0;
    exi.ex_addr = '0;
    exi.ex_wdata = '0;
    exi.ex_rd = '0;
    mem_clr = 1'b1;
    idle(2);
    mem_clr = 1'b0;
    chk("rst_ready", 32'(exi.ex_ready), 32'd0);
    chk("rst_wen", 32'(dmem_wen), 32'd0);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    resetn = 1'b1;
    idle(1);
    chk("idle_ready", 32'(exi.ex_ready), 32'd1);

    backdoor(4, 32'h80FF_1234);
    req(OP_LB, 32'h13, 32'h0, 5'd1);
    chk("lb13", wb_data, 32'hFFFF_FF80);
    chk("lb13_v", 32'(wb_valid), 32'd1);
    req(OP_LBU, 32'h13, 32'h0, 5'd2);
    chk("lbu13", wb_data, 32'h0000_0080);
    req(OP_LH, 32'h12, 32'h0, 5'd3);
    chk("lh12", wb_data, 32'hFFFF_80FF);

    req(OP_SW, 32'h20, 32'hDEAD_BEEF, 5'd0);
    req(OP_LW, 32'h20, 32'h0, 5'd7);
    chk("sw_lw", wb_data, 32'hDEAD_BEEF);
    chk("sw_lw_rd", 32'(wb_rd), 32'd7);

    backdoor(9, 32'h1122_3344);
    req(OP_SB, 32'h25, 32'h0000_00AA, 5'd0);
    chk("rmw_ready", 32'(exi.ex_ready), 32'd0);
    chk("rmw_wen", 32'(dmem_wen), 32'd1);
    req(OP_LW, 32'h24, 32'h0, 5'd9);
    chk("sb_lw", wb_data, 32'h1122_AA44);

    req(OP_LW, 32'h22, 32'h0, 5'd4);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_err", 32'(misalign_err), 32'd1);
    chk("mis_wbv", 32'(wb_valid), 32'd0);
`else
    chk("mis_wbv", 32'(wb_valid), 32'd1);
    chk("mis_data", wb_data, 32'hDEAD_BEEF);
`endif

    backdoor(1, 32'h0404_CAFE);
    req(OP_LW, 32'h0000_0104, 32'h0, 5'd0);
    chk("lw104", wb_data, 32'h0404_CAFE);

    backdoor(12, 32'h5566_7788);
    req(OP_SH, 32'h32, 32'h0000_BEEF, 5'd0);
    resetn = 1'b0;
    idle(1);
    chk("rst_rmw_mem", dut_mem[12], 32'h5566_7788);
    chk("rst_rmw_wbv", 32'(wb_valid), 32'd0);
    chk("rst_rmw_data", wb_data, 32'h0);
    chk("rst_rmw_wen", 32'(dmem_wen), 32'd0);
    resetn = 1'b1;
    idle(1);

    for (int c = 0; c < 3000; c++) begin
      if (!(exi.ex_valid && !acc_now)) begin
        r = $urandom();
        exi.ex_valid = ($urandom_range(0, 9) < 7);
        exi.ex_op = ($urandom_range(0, 19) == 0) ?
                    4'($urandom_range(9, 15)) :
                    4'($urandom_range(0, 8));
        exi.ex_addr = {r[31:8], 3'b000,
                       5'($urandom_range(0, 31))};
        exi.ex_wdata = $urandom();
        exi.ex_rd = 5'($urandom_range(0, 31));
      end
      resetn = ($urandom_range(0, 99) != 0);
      idle(1);
    end
    resetn = 1'b1;
    exi.ex_valid = 1'b0;
    idle(3);
    for (int i = 0; i < 64; i++) chk("mem_final", dut_mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
